// File: rtl/coport_arb.sv
// coport_arb -- arbiter for one coherence-hub slave port shared by RN requesters.
//
// The hub holds only one request per port, so at most one transaction is in
// flight at a time. Each issued transaction carries a nonzero 8-bit id that
// cycles 1..255. The hub response is steered back to the requester that issued
// it, and the block also runs the hub's exclusive-lock handshake.
//
// Build option:
//   COPORT_TIMEOUT_EN  when defined, a transaction that sees no response within
//                      TMO_CYC cycles of WAIT completes with rsp_err=1. When not
//                      defined, WAIT ends only on a matching h_resp and rsp_err
//                      is tied to 0.
//
// Parameters:
//   RN       number of requesters (2..8)
//   TMO_CYC  response timeout in cycles (only used with COPORT_TIMEOUT_EN)
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester request, held until req_ready
//   req_trsc     per-requester transaction type, 8 bits each
//   req_addr     per-requester line address, 64 bits each
//   req_ready    one-hot accept pulse (combinational, IDLE only)
//   rsp_valid    one-hot completion pulse
//   rsp_mesi     state returned with rsp_valid
//   rsp_err      completion caused by timeout
//   lock_req     per-requester lock request (level)
//   lock_gnt     lock confirmed to the owning requester
//   h_lock       lock request to the hub
//   h_lock_ack   hub lock confirmation
//   h_rqst       transaction id, nonzero only in the single issue cycle
//   h_trsc       transaction type to the hub (issue cycle only)
//   h_addr       address to the hub (issue cycle only)
//   h_resp       completed transaction id from the hub (one-cycle pulse)
//   h_mesi       state accompanying h_resp
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing in flight; lock claim or round-robin grant possible
// S_ISSUE | registered request presented on h_rqst/h_trsc/h_addr
// S_WAIT  | waiting for h_resp matching the current id

module coport_arb #(
    parameter int RN      = 2,
    parameter int TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RN-1:0]    req_valid,
    input  logic [RN*8-1:0]  req_trsc,
    input  logic [RN*64-1:0] req_addr,
    output logic [RN-1:0]    req_ready,
    output logic [RN-1:0]    rsp_valid,
    output logic [7:0]       rsp_mesi,
    output logic             rsp_err,
    input  logic [RN-1:0]    lock_req,
    output logic [RN-1:0]    lock_gnt,
    output logic             h_lock,
    input  logic             h_lock_ack,
    output logic [7:0]       h_rqst,
    output logic [7:0]       h_trsc,
    output logic [63:0]      h_addr,
    input  logic [7:0]       h_resp,
    input  logic [7:0]       h_mesi
);

    localparam int            IW  = (RN > 1) ? $clog2(RN) : 1;
    localparam logic [RN-1:0] ONE = {{(RN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    trsc_arr [RN];
    logic [63:0]   addr_arr [RN];

    logic [7:0]    id_q;
    logic [7:0]    id_next;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] win_q;
    logic [IW-1:0] own_q;
    logic          own_vld_q;

    logic [RN-1:0] elig;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] lock_idx;
    logic          grant;
    logic          lock_claim;
    logic          lock_release;
    logic          resp_hit;
    logic          tmo_hit;
    logic          done;

    logic [7:0]    h_rqst_q;
    logic [7:0]    h_trsc_q;
    logic [63:0]   h_addr_q;
    logic [RN-1:0] rsp_valid_q;
    logic [7:0]    rsp_mesi_q;

    for (genvar g = 0; g < RN; g++) begin : g_unpack
        assign trsc_arr[g] = req_trsc[g*8 +: 8];
        assign addr_arr[g] = req_addr[g*64 +: 64];
    end

    // First set bit of v, scanning upward from p and wrapping at RN.
    function automatic logic [IW-1:0] rr_pick(input logic [RN-1:0] v,
                                              input logic [IW-1:0] p);
        logic [IW-1:0] r;
        logic          hit;
        int            j;
        r   = '0;
        hit = 1'b0;
        for (int k = 0; k < RN; k++) begin
            j = int'(p) + k;
            if (j >= RN) j = j - RN;
            if (!hit && v[IW'(j)]) begin
                hit = 1'b1;
                r   = IW'(j);
            end
        end
        return r;
    endfunction

    always_comb begin
        // While a lock is held only the owner may issue.
        elig         = own_vld_q ? (req_valid & (ONE << own_q)) : req_valid;
        gnt_idx      = rr_pick(elig, rr_ptr_q);
        lock_idx     = rr_pick(lock_req, rr_ptr_q);
        ptr_next     = (gnt_idx == IW'(RN - 1)) ? '0 : gnt_idx + IW'(1);
        // Id 0 is reserved as "no request" on h_rqst, so skip it on wrap.
        id_next      = (id_q == 8'hFF) ? 8'h01 : id_q + 8'h01;
        lock_release = own_vld_q & ~lock_req[own_q];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        lock_claim = 1'b0;
        grant      = 1'b0;
        resp_hit   = 1'b0;
        done       = 1'b0;
        req_ready  = '0;
        case (state_q)
            S_IDLE: begin
                // A lock claim takes the whole IDLE cycle; any request,
                // including the new owner's, is granted on the next IDLE cycle.
                lock_claim = !own_vld_q && (|lock_req);
                grant      = !lock_claim && (|elig);
                if (grant) begin
                    req_ready = ONE << gnt_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                resp_hit = (h_resp == id_q);
                done     = resp_hit | tmo_hit;
                if (done) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q        <= 8'h01;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            own_q       <= '0;
            own_vld_q   <= 1'b0;
            h_rqst_q    <= '0;
            h_trsc_q    <= '0;
            h_addr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_mesi_q  <= '0;
        end else begin
            // Hub-side fields are only nonzero for the single ISSUE cycle.
            h_rqst_q    <= '0;
            h_trsc_q    <= '0;
            h_addr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_mesi_q  <= '0;
            if (grant) begin
                h_rqst_q <= id_q;
                h_trsc_q <= trsc_arr[gnt_idx];
                h_addr_q <= addr_arr[gnt_idx];
                win_q    <= gnt_idx;
                rr_ptr_q <= ptr_next;
            end
            if (done) begin
                rsp_valid_q <= ONE << win_q;
                rsp_mesi_q  <= resp_hit ? h_mesi : 8'h00;
                id_q        <= id_next;
            end
            if (lock_claim) begin
                own_q     <= lock_idx;
                own_vld_q <= 1'b1;
            end else if (lock_release) begin
                own_vld_q <= 1'b0;
            end
        end
    end

`ifdef COPORT_TIMEOUT_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q;

    // Down-counter loaded during ISSUE so it reads TMO_CYC-1 in the first WAIT
    // cycle; terminal count 0 in the TMO_CYC-th WAIT cycle ends the wait.
    assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                tmo_cnt_q <= TW'(TMO_CYC - 1);
            else if ((state_q == S_WAIT) && !done)
                tmo_cnt_q <= tmo_cnt_q - TW'(1);
            else
                tmo_cnt_q <= '0;
            // A real response in the terminal cycle wins over the timeout.
            rsp_err_q <= done && !resp_hit;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    // Without the timeout, WAIT ends only on a matching h_resp. TMO_CYC is
    // still referenced so both builds share one parameter list.
    if (TMO_CYC >= 1) begin : g_no_tmo
        assign tmo_hit = 1'b0;
    end else begin : g_no_tmo_zero
        assign tmo_hit = 1'b0;
    end

    assign rsp_err = 1'b0;
`endif

    assign h_rqst    = h_rqst_q;
    assign h_trsc    = h_trsc_q;
    assign h_addr    = h_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mesi  = rsp_mesi_q;
    assign h_lock    = own_vld_q;
    assign lock_gnt  = (h_lock_ack && own_vld_q) ? (ONE << own_q) : '0;

endmodule

// File: tb/tb_coport_arb.sv
// tb_coport_arb -- directed bench for coport_arb (RN=2, TMO_CYC=16).
// Inputs are driven at the falling edge and outputs sampled 1 time unit later,
// so each falling edge marks one cycle of the design.

module tb_coport_arb;

    localparam int RN = 2;
    localparam logic [63:0] A0 = 64'h0000_0000_8000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_2040;

    logic           clk = 1'b0;
    logic           rst;
    logic [RN-1:0]  req_valid;
    logic [RN*8-1:0]  req_trsc;
    logic [RN*64-1:0] req_addr;
    logic [RN-1:0]  req_ready;
    logic [RN-1:0]  rsp_valid;
    logic [7:0]     rsp_mesi;
    logic           rsp_err;
    logic [RN-1:0]  lock_req;
    logic [RN-1:0]  lock_gnt;
    logic           h_lock;
    logic           h_lock_ack;
    logic [7:0]     h_rqst;
    logic [7:0]     h_trsc;
    logic [63:0]    h_addr;
    logic [7:0]     h_resp;
    logic [7:0]     h_mesi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    coport_arb #(.RN(RN), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_trsc(req_trsc), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_mesi(rsp_mesi),
        .rsp_err(rsp_err), .lock_req(lock_req), .lock_gnt(lock_gnt),
        .h_lock(h_lock), .h_lock_ack(h_lock_ack), .h_rqst(h_rqst),
        .h_trsc(h_trsc), .h_addr(h_addr), .h_resp(h_resp), .h_mesi(h_mesi)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; lock_req = '0; h_lock_ack = 1'b0;
        h_resp = '0; h_mesi = '0;
        req_trsc = {8'h00, 8'h01};
        req_addr = {A1, A0};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h00) begin n_err++; $display("FAIL reset_rsp_mesi got=%h want=00", rsp_mesi); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        n_vec++; if (lock_gnt !== 2'b00) begin n_err++; $display("FAIL reset_lock_gnt got=%b want=00", lock_gnt); end
        n_vec++; if (h_lock !== 1'b0) begin n_err++; $display("FAIL reset_h_lock got=%b want=0", h_lock); end
        n_vec++; if (h_rqst !== 8'h00) begin n_err++; $display("FAIL reset_h_rqst got=%h want=00", h_rqst); end
        n_vec++; if (h_trsc !== 8'h00) begin n_err++; $display("FAIL reset_h_trsc got=%h want=00", h_trsc); end
        n_vec++; if (h_addr !== 64'h0) begin n_err++; $display("FAIL reset_h_addr got=%h want=0", h_addr); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk); req_valid = 2'b01; #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h01) begin n_err++; $display("FAIL single_h_rqst got=%h want=01", h_rqst); end
        n_vec++; if (h_trsc !== 8'h01) begin n_err++; $display("FAIL single_h_trsc got=%h want=01", h_trsc); end
        n_vec++; if (h_addr !== A0) begin n_err++; $display("FAIL single_h_addr got=%h want=%h", h_addr, A0); end
        @(negedge clk); #1;
        n_vec++; if (h_rqst !== 8'h00) begin n_err++; $display("FAIL single_h_rqst_clr got=%h want=00", h_rqst); end
        n_vec++; if (h_addr !== 64'h0) begin n_err++; $display("FAIL single_h_addr_clr got=%h want=0", h_addr); end
        @(negedge clk);
        @(negedge clk); h_resp = 8'h01; h_mesi = 8'h01; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_early got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h01) begin n_err++; $display("FAIL single_rsp_mesi got=%h want=01", rsp_mesi); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err got=%b want=0", rsp_err); end
        @(negedge clk); #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_pulse got=%b want=00", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ew;
        logic [1:0]  pw;
        logic [7:0]  eid;
        logic [7:0]  et;
        logic [63:0] ea;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ew  = (k % 2 == 0) ? 2'b01 : 2'b10;
            pw  = (k % 2 == 0) ? 2'b10 : 2'b01;
            eid = 8'(k + 1);
            et  = (k % 2 == 0) ? 8'h01 : 8'h00;
            ea  = (k % 2 == 0) ? A0 : A1;
            @(negedge clk); req_valid = 2'b11; h_resp = 8'h00; #1;
            n_vec++; if (req_ready !== ew) begin n_err++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, req_ready, ew); end
            if (k > 0) begin
                n_vec++; if (rsp_valid !== pw) begin n_err++; $display("FAIL b2b_rsp k=%0d got=%b want=%b", k, rsp_valid, pw); end
                n_vec++; if (rsp_mesi !== 8'(8'h10 + k - 1)) begin n_err++; $display("FAIL b2b_mesi k=%0d got=%h want=%h", k, rsp_mesi, 8'(8'h10 + k - 1)); end
            end
            @(negedge clk); #1;
            n_vec++; if (h_rqst !== eid) begin n_err++; $display("FAIL b2b_id k=%0d got=%h want=%h", k, h_rqst, eid); end
            n_vec++; if (h_trsc !== et) begin n_err++; $display("FAIL b2b_trsc k=%0d got=%h want=%h", k, h_trsc, et); end
            n_vec++; if (h_addr !== ea) begin n_err++; $display("FAIL b2b_addr k=%0d got=%h want=%h", k, h_addr, ea); end
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL b2b_busy_issue k=%0d got=%b want=00", k, req_ready); end
            @(negedge clk); h_resp = eid; h_mesi = 8'(8'h10 + k); #1;
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL b2b_busy_wait k=%0d got=%b want=00", k, req_ready); end
        end
        @(negedge clk); req_valid = 2'b00; h_resp = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL b2b_rsp_last got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h12) begin n_err++; $display("FAIL b2b_mesi_last got=%h want=12", rsp_mesi); end
    endtask

    task automatic test_id_wrap();
        logic [7:0] eid;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            eid = 8'((k % 255) + 1);
            @(negedge clk); req_valid = 2'b01; h_resp = 8'h00; #1;
            n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wrap_ready k=%0d got=%b want=01", k, req_ready); end
            if (k > 0) begin
                n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL wrap_rsp k=%0d got=%b want=01", k, rsp_valid); end
            end
            @(negedge clk); #1;
            n_vec++; if (h_rqst !== eid) begin n_err++; $display("FAIL wrap_id k=%0d got=%h want=%h", k, h_rqst, eid); end
            @(negedge clk); h_resp = eid; #1;
        end
        @(negedge clk); req_valid = 2'b00; h_resp = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL wrap_rsp_last got=%b want=01", rsp_valid); end
    endtask

    task automatic test_stale_resp();
        do_reset();
        @(negedge clk); h_resp = 8'h07; #1;
        @(negedge clk); h_resp = 8'h01; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL stale_idle07 got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h00; req_valid = 2'b01; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL stale_idle01 got=%b want=00", rsp_valid); end
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL stale_ready got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; h_resp = 8'h01; #1;
        n_vec++; if (h_rqst !== 8'h01) begin n_err++; $display("FAIL stale_id got=%h want=01", h_rqst); end
        @(negedge clk); h_resp = 8'h05; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL stale_issue_resp got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL stale_wrong_id got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h01; h_mesi = 8'h03; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL stale_wait got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL stale_good got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h03) begin n_err++; $display("FAIL stale_mesi got=%h want=03", rsp_mesi); end
    endtask

    // Continues from test_stale_resp: next id is 2, RR pointer is 1.
    task automatic test_lock();
        @(negedge clk); lock_req = 2'b10; req_valid = 2'b01; h_lock_ack = 1'b1; #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_claim_ready got=%b want=00", req_ready); end
        n_vec++; if (h_lock !== 1'b0) begin n_err++; $display("FAIL lock_claim_h_lock got=%b want=0", h_lock); end
        @(negedge clk); #1;
        n_vec++; if (h_lock !== 1'b1) begin n_err++; $display("FAIL lock_h_lock got=%b want=1", h_lock); end
        n_vec++; if (lock_gnt !== 2'b10) begin n_err++; $display("FAIL lock_gnt got=%b want=10", lock_gnt); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_masked got=%b want=00", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_hold c=%0d got=%b want=00", c, req_ready); end
        end
        @(negedge clk); lock_req = 2'b00; #1;
        n_vec++; if (h_lock !== 1'b1) begin n_err++; $display("FAIL lock_drop_h_lock got=%b want=1", h_lock); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_drop_ready got=%b want=00", req_ready); end
        @(negedge clk); #1;
        n_vec++; if (h_lock !== 1'b0) begin n_err++; $display("FAIL lock_rel_h_lock got=%b want=0", h_lock); end
        n_vec++; if (lock_gnt !== 2'b00) begin n_err++; $display("FAIL lock_rel_gnt got=%b want=00", lock_gnt); end
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL lock_rel_ready got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h02) begin n_err++; $display("FAIL lock_id got=%h want=02", h_rqst); end
        @(negedge clk); h_resp = 8'h02; h_mesi = 8'h04; #1;
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL lock_rsp got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h04) begin n_err++; $display("FAIL lock_mesi got=%h want=04", rsp_mesi); end
    endtask

    // Continues from test_lock: next id is 3, RR pointer is 1, h_lock_ack high.
    task automatic test_lock_owner_req();
        @(negedge clk); lock_req = 2'b01; req_valid = 2'b11; #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL own_claim_ready got=%b want=00", req_ready); end
        @(negedge clk); #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL own_ready got=%b want=01", req_ready); end
        n_vec++; if (lock_gnt !== 2'b01) begin n_err++; $display("FAIL own_gnt got=%b want=01", lock_gnt); end
        @(negedge clk); req_valid = 2'b10; #1;
        n_vec++; if (h_rqst !== 8'h03) begin n_err++; $display("FAIL own_id got=%h want=03", h_rqst); end
        n_vec++; if (h_addr !== A0) begin n_err++; $display("FAIL own_addr got=%h want=%h", h_addr, A0); end
        @(negedge clk); h_resp = 8'h03; h_mesi = 8'h06; #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL own_wait_ready got=%b want=00", req_ready); end
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; lock_req = 2'b00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL own_rsp got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h06) begin n_err++; $display("FAIL own_mesi got=%h want=06", rsp_mesi); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL own_still_masked got=%b want=00", req_ready); end
        @(negedge clk); #1;
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL own_r1_ready got=%b want=10", req_ready); end
        n_vec++; if (h_lock !== 1'b0) begin n_err++; $display("FAIL own_h_lock got=%b want=0", h_lock); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h04) begin n_err++; $display("FAIL own_r1_id got=%h want=04", h_rqst); end
        n_vec++; if (h_addr !== A1) begin n_err++; $display("FAIL own_r1_addr got=%h want=%h", h_addr, A1); end
        @(negedge clk); h_resp = 8'h04; h_mesi = 8'h07; #1;
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; h_lock_ack = 1'b0; #1;
        n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL own_r1_rsp got=%b want=10", rsp_valid); end
        n_vec++; if (rsp_mesi !== 8'h07) begin n_err++; $display("FAIL own_r1_mesi got=%h want=07", rsp_mesi); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); req_valid = 2'b01; #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ready got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        @(negedge clk); h_resp = 8'h01; h_mesi = 8'h02; rst = 1'b1; #1;
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; rst = 1'b0; req_valid = 2'b11; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_dropped got=%b want=00", rsp_valid); end
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ptr_reset got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h01) begin n_err++; $display("FAIL mid_id_reset got=%h want=01", h_rqst); end
        @(negedge clk); h_resp = 8'h01; h_mesi = 8'h02; #1;
        @(negedge clk); h_resp = 8'h00; h_mesi = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL mid_rsp got=%b want=01", rsp_valid); end
    endtask

`ifdef COPORT_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        @(negedge clk); req_valid = 2'b01; h_mesi = 8'h09; #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL tmo_ready got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h01) begin n_err++; $display("FAIL tmo_id got=%h want=01", h_rqst); end
        for (int c = 2; c < 18; c++) begin
            @(negedge clk); #1;
            n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL tmo_early c=%0d got=%b want=00", c, rsp_valid); end
        end
        @(negedge clk); req_valid = 2'b01; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL tmo_rsp got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b want=1", rsp_err); end
        n_vec++; if (rsp_mesi !== 8'h00) begin n_err++; $display("FAIL tmo_mesi got=%h want=00", rsp_mesi); end
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL tmo_regrant got=%b want=01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_vec++; if (h_rqst !== 8'h02) begin n_err++; $display("FAIL tmo_id2 got=%h want=02", h_rqst); end
        @(negedge clk); h_resp = 8'h01; h_mesi = 8'h05; #1;
        @(negedge clk); h_resp = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL tmo_late_ignored got=%b want=00", rsp_valid); end
        @(negedge clk); h_resp = 8'h02; #1;
        @(negedge clk); h_resp = 8'h00; #1;
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL tmo_next_rsp got=%b want=01", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL tmo_next_err got=%b want=0", rsp_err); end
        n_vec++; if (rsp_mesi !== 8'h05) begin n_err++; $display("FAIL tmo_next_mesi got=%h want=05", rsp_mesi); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached without finishing", $time);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = '0; lock_req = '0; h_lock_ack = 1'b0;
        h_resp = '0; h_mesi = '0; req_trsc = '0; req_addr = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_id_wrap();
        test_stale_resp();
        test_lock();
        test_lock_owner_req();
        test_reset_mid();
`ifdef COPORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
